mopshub_top_ctrl: RTL and testbench

Start-up sequencer for the MOPSHUB top level. After reset it runs three phases in order. First it issues a bus reset. Then it powers the CAN buses one at a time, optionally trimming each bus node's oscillator. Finally it signs on the hub. All phase boundaries are exported as single-cycle strobes for the data generator and the debug monitor.

---
 rtl/mopshub_ctrl_pkg.sv | 35 +++
 rtl/mopshub_wait_timer.sv | 27 ++
 rtl/mopshub_top_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mopshub_top_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mopshub_ctrl_pkg.sv
// Shared types and constants for the MOPSHUB start-up sequencer.
package mopshub_ctrl_pkg;

  localparam int unsigned BUS_IDX_W               = 5;
  localparam int unsigned NUM_BUSES               = 32;
  localparam int unsigned DEF_RST_BUS_CYCLES      = 8;
  localparam int unsigned DEF_POWER_WAIT_CYCLES   = 16;
  localparam int unsigned DEF_TRIM_TIMEOUT_CYCLES = 4096;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    POWER,
    TRIM,
    NEXT,
    DONE,
    SIGN_ON,
    READY
  } ctrl_state_e;

  // A wait of N cycles loads N-1; a zero-cycle wait still occupies one cycle.
  function automatic int unsigned wait_load(input int unsigned cycles);
    return (cycles == 0) ? 0 : cycles - 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/mopshub_wait_timer.sv
// Loadable down-counter; expires at zero or when forced.
module mopshub_wait_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_force,
  output logic             o_expire_c
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expire_c = (r_cnt == '0) || i_force;

endmodule

// File: rtl/mopshub_top_ctrl.sv
// MOPSHUB start-up sequencer: bus reset, per-bus power/trim, sign-on.
// Optional macro MOPSHUB_TRIM_TIMEOUT_EN adds a trim timeout and trim_fail_mask.
module mopshub_top_ctrl
  import mopshub_ctrl_pkg::*;
#(
  parameter int unsigned RST_BUS_CYCLES      = DEF_RST_BUS_CYCLES,
  parameter int unsigned POWER_WAIT_CYCLES   = DEF_POWER_WAIT_CYCLES,
  parameter int unsigned TRIM_TIMEOUT_CYCLES = DEF_TRIM_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_IDX_W-1:0] n_buses,
  input  logic                 osc_auto_trim_mopshub,
  input  logic                 trim_ack_in,
  input  logic                 endwait_all,
  output logic                 rst_bus,
  output logic                 start_init,
  output logic                 end_init,
  output logic                 power_bus_en,
  output logic [BUS_IDX_W-1:0] power_bus_cnt,
  output logic                 start_trim_ack,
  output logic                 end_trim_bus,
  output logic                 ext_counter_gen,
  output logic                 end_power_init,
  output logic                 sign_on_sig
`ifdef MOPSHUB_TRIM_TIMEOUT_EN
  ,
  output logic [NUM_BUSES-1:0] trim_fail_mask
`endif
);

  localparam int unsigned CNT_W = cnt_width(RST_BUS_CYCLES, POWER_WAIT_CYCLES,
                                            TRIM_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LD_RST  = CNT_W'(wait_load(RST_BUS_CYCLES));
  localparam logic [CNT_W-1:0] LD_PWR  = CNT_W'(wait_load(POWER_WAIT_CYCLES));
  localparam logic [CNT_W-1:0] LD_TRIM = CNT_W'(wait_load(TRIM_TIMEOUT_CYCLES));

  ctrl_state_e      r_state;
  logic             w_wait_done;
  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_val;
  logic             w_tmr_force;
  logic             w_trim_done;

  // Timer is reloaded on the edge that enters each waiting state.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = LD_PWR;
    case (r_state)
      IDLE: begin
        w_tmr_load = 1'b1;
        w_tmr_val  = LD_RST;
      end
      INIT: begin
        w_tmr_load = w_wait_done;
        w_tmr_val  = LD_PWR;
      end
      POWER: begin
        w_tmr_load = w_wait_done;
        w_tmr_val  = LD_TRIM;
      end
      NEXT: begin
        w_tmr_load = 1'b1;
        w_tmr_val  = LD_PWR;
      end
      default: begin
        w_tmr_load = 1'b0;
      end
    endcase
  end

  assign w_tmr_force = endwait_all && ((r_state == INIT) || (r_state == POWER));

`ifdef MOPSHUB_TRIM_TIMEOUT_EN
  assign w_trim_done = trim_ack_in || endwait_all || w_wait_done;
`else
  assign w_trim_done = trim_ack_in || endwait_all;
`endif

  mopshub_wait_timer #(
    .CNT_W (CNT_W)
  ) u_wait_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_force    (w_tmr_force),
    .o_expire_c (w_wait_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= IDLE;
      rst_bus         <= 1'b0;
      start_init      <= 1'b0;
      end_init        <= 1'b0;
      power_bus_en    <= 1'b0;
      power_bus_cnt   <= '0;
      start_trim_ack  <= 1'b0;
      end_trim_bus    <= 1'b0;
      ext_counter_gen <= 1'b0;
      end_power_init  <= 1'b0;
      sign_on_sig     <= 1'b0;
`ifdef MOPSHUB_TRIM_TIMEOUT_EN
      trim_fail_mask  <= '0;
`endif
    end else begin
      start_init      <= 1'b0;
      end_init        <= 1'b0;
      start_trim_ack  <= 1'b0;
      end_trim_bus    <= 1'b0;
      ext_counter_gen <= 1'b0;
      end_power_init  <= 1'b0;
      sign_on_sig     <= 1'b0;
      case (r_state)
        IDLE: begin
          r_state    <= INIT;
          start_init <= 1'b1;
          rst_bus    <= 1'b1;
        end
        INIT: begin
          if (w_wait_done) begin
            r_state       <= POWER;
            rst_bus       <= 1'b0;
            power_bus_cnt <= '0;
            power_bus_en  <= 1'b1;
          end
        end
        POWER: begin
          if (w_wait_done) begin
            if (osc_auto_trim_mopshub) begin
              r_state        <= TRIM;
              start_trim_ack <= 1'b1;
            end else begin
              r_state         <= NEXT;
              power_bus_en    <= 1'b0;
              ext_counter_gen <= 1'b1;
            end
          end
        end
        TRIM: begin
          if (w_trim_done) begin
            r_state         <= NEXT;
            end_trim_bus    <= 1'b1;
            power_bus_en    <= 1'b0;
            ext_counter_gen <= 1'b1;
`ifdef MOPSHUB_TRIM_TIMEOUT_EN
            if (w_wait_done && !trim_ack_in) begin
              trim_fail_mask[power_bus_cnt] <= 1'b1;
            end
`endif
          end
        end
        NEXT: begin
          // >= keeps the index from running past a lowered n_buses.
          if (power_bus_cnt >= n_buses) begin
            r_state        <= DONE;
            end_power_init <= 1'b1;
          end else begin
            r_state       <= POWER;
            power_bus_cnt <= power_bus_cnt + BUS_IDX_W'(1);
            power_bus_en  <= 1'b1;
          end
        end
        DONE: begin
          r_state  <= SIGN_ON;
          end_init <= 1'b1;
        end
        SIGN_ON: begin
          r_state     <= READY;
          sign_on_sig <= 1'b1;
        end
        READY: begin
          r_state <= READY;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mopshub_top_ctrl.sv
// Randomized bench for mopshub_top_ctrl against a cycle-trace reference model.
// Define MOPSHUB_TRIM_TIMEOUT_EN to also cover the trim timeout and fail mask.
module tb_mopshub_top_ctrl;
  import mopshub_ctrl_pkg::*;

  localparam int unsigned RST_C  = 8;
  localparam int unsigned PWR_C  = 16;
  localparam int unsigned TRIM_C = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] n_buses = '0;
  logic       osc_auto_trim_mopshub = 1'b0;
  logic       trim_ack_in = 1'b0;
  logic       endwait_all = 1'b0;
  logic       rst_bus, start_init, end_init, power_bus_en;
  logic [4:0] power_bus_cnt;
  logic       start_trim_ack, end_trim_bus, ext_counter_gen, end_power_init, sign_on_sig;
`ifdef MOPSHUB_TRIM_TIMEOUT_EN
  logic [31:0] trim_fail_mask;
`endif

  int checks   = 0;
  int failures = 0;

  mopshub_top_ctrl #(
    .RST_BUS_CYCLES      (RST_C),
    .POWER_WAIT_CYCLES   (PWR_C),
    .TRIM_TIMEOUT_CYCLES (TRIM_C)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .n_buses               (n_buses),
    .osc_auto_trim_mopshub (osc_auto_trim_mopshub),
    .trim_ack_in           (trim_ack_in),
    .endwait_all           (endwait_all),
    .rst_bus               (rst_bus),
    .start_init            (start_init),
    .end_init              (end_init),
    .power_bus_en          (power_bus_en),
    .power_bus_cnt         (power_bus_cnt),
    .start_trim_ack        (start_trim_ack),
    .end_trim_bus          (end_trim_bus),
    .ext_counter_gen       (ext_counter_gen),
    .end_power_init        (end_power_init),
    .sign_on_sig           (sign_on_sig)
`ifdef MOPSHUB_TRIM_TIMEOUT_EN
    ,
    .trim_fail_mask        (trim_fail_mask)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst_bus;
    logic        start_init;
    logic        end_init;
    logic        en;
    logic [4:0]  cnt;
    logic        start_trim;
    logic        end_trim;
    logic        ext;
    logic        end_pwr;
    logic        sign_on;
    logic [31:0] mask;
  } exp_t;

  exp_t exp_q[$];
  logic ack_q[$];
  logic ew_q[$];
  logic trm_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit rnd();
    return ($urandom_range(0, 3) == 0);
  endfunction

  function automatic logic [13:0] obs_vec();
    return {rst_bus, start_init, end_init, power_bus_en, power_bus_cnt,
            start_trim_ack, end_trim_bus, ext_counter_gen, end_power_init, sign_on_sig};
  endfunction

  function automatic logic [13:0] exp_vec(input exp_t e);
    return {e.rst_bus, e.start_init, e.end_init, e.en, e.cnt,
            e.start_trim, e.end_trim, e.ext, e.end_pwr, e.sign_on};
  endfunction

  task automatic add(input exp_t e, input logic a, input logic w, input logic t);
    exp_q.push_back(e);
    ack_q.push_back(a);
    ew_q.push_back(w);
    trm_q.push_back(t);
  endtask

  // Expected per-cycle outputs plus the inputs to drive, from edge 0 after release.
  // trim_mode: 0 off, 1 on, 2 random per bus. tk: trim end kind 0 ack,1 endwait,2 both,3 silent.
  task automatic build(input int n, input int trim_mode, input int ew_init,
                       input int tk, input int td, input bit noise);
    exp_t        e;
    logic [31:0] mask;
    int          pe, kind, d, jx;
    logic        tb, a, w;
    exp_q.delete(); ack_q.delete(); ew_q.delete(); trm_q.delete();
    mask = '0;
    for (int i = 0; i < int'(RST_C); i++) begin
      e = '0; e.rst_bus = 1'b1; e.start_init = (i == 0);
      w = (i == ew_init);
      add(e, noise && rnd(), w, rnd());
      if (w) break;
    end
    for (int b = 0; b <= n; b++) begin
      tb = (trim_mode == 2) ? 1'($urandom_range(0, 1)) : (trim_mode == 1);
      pe = (noise && rnd()) ? int'($urandom_range(0, PWR_C - 1)) : -1;
      for (int i = 0; i < int'(PWR_C); i++) begin
        e = '0; e.en = 1'b1; e.cnt = 5'(b); e.mask = mask;
        w = (i == pe);
        add(e, noise && rnd(), w, tb);
        if (w) break;
      end
      if (tb) begin
        kind = (tk >= 0) ? tk : int'($urandom_range(0, 3));
        d    = (td >= 0) ? td : int'($urandom_range(0, 12));
`ifdef MOPSHUB_TRIM_TIMEOUT_EN
        if (kind == 3) d = 1000;
        jx = (d > int'(TRIM_C) - 1) ? int'(TRIM_C) - 1 : d;
`else
        if (kind == 3) kind = 1;
        jx = d;
`endif
        for (int j = 0; j <= jx; j++) begin
          e = '0; e.en = 1'b1; e.cnt = 5'(b); e.start_trim = (j == 0); e.mask = mask;
          a = (j == d) && (kind == 0 || kind == 2);
          w = (j == d) && (kind == 1 || kind == 2);
          add(e, a, w, rnd());
        end
`ifdef MOPSHUB_TRIM_TIMEOUT_EN
        if (jx == int'(TRIM_C) - 1 && !(jx == d && (kind == 0 || kind == 2))) mask[b] = 1'b1;
`endif
      end
      e = '0; e.ext = 1'b1; e.end_trim = tb; e.cnt = 5'(b); e.mask = mask;
      add(e, noise && rnd(), noise && rnd(), rnd());
    end
    e = '0; e.cnt = 5'(n); e.mask = mask; e.end_pwr = 1'b1;
    add(e, noise && rnd(), noise && rnd(), rnd());
    e.end_pwr = 1'b0; e.end_init = 1'b1;
    add(e, noise && rnd(), noise && rnd(), rnd());
    e.end_init = 1'b0; e.sign_on = 1'b1;
    add(e, noise && rnd(), noise && rnd(), rnd());
    e.sign_on = 1'b0;
    for (int i = 0; i < 4; i++) add(e, noise && rnd(), noise && rnd(), rnd());
  endtask

  task automatic run(input string name, input int n, input int abort_at);
    int ext_seen;
    bit aborted;
    ext_seen = 0;
    aborted  = 1'b0;
    n_buses  = 5'(n);
    @(negedge clk);
    check($sformatf("%s reset_outs", name), 64'(obs_vec()), 64'(0));
`ifdef MOPSHUB_TRIM_TIMEOUT_EN
    check($sformatf("%s reset_mask", name), 64'(trim_fail_mask), 64'(0));
`endif
    rst = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk);
      #1;
      trim_ack_in           = ack_q[i];
      endwait_all           = ew_q[i];
      osc_auto_trim_mopshub = trm_q[i];
      @(negedge clk);
      check($sformatf("%s cyc%0d outs", name, i), 64'(obs_vec()), 64'(exp_vec(exp_q[i])));
`ifdef MOPSHUB_TRIM_TIMEOUT_EN
      check($sformatf("%s cyc%0d mask", name, i), 64'(trim_fail_mask), 64'(exp_q[i].mask));
`endif
      if (ext_counter_gen) ext_seen++;
      if (i == abort_at) begin
        rst = 1'b0;
        #1;
        check($sformatf("%s async_reset_outs", name), 64'(obs_vec()), 64'(0));
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) check($sformatf("%s ext_strobes", name), 64'(ext_seen), 64'(n + 1));
    @(negedge clk);
    rst = 1'b0;
    trim_ack_in = 1'b0;
    endwait_all = 1'b0;
    osc_auto_trim_mopshub = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int abort_at;
    int n;
    repeat (3) @(negedge clk);
    build(31, 0, -1, -1, -1, 1'b0);  run("all32", 31, -1);
    build(2, 1, -1, 0, 5, 1'b0);     run("trim_ack", 2, -1);
    build(1, 1, -1, 1, 100, 1'b0);   run("trim_ew", 1, -1);
    build(3, 0, 1, -1, -1, 1'b0);    run("init_ew", 3, -1);
    build(31, 2, -1, -1, -1, 1'b1);
    abort_at = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].en && exp_q[i].cnt == 5'd7) begin
        abort_at = i;
        break;
      end
    end
    run("abort7", 31, abort_at);
    build(2, 0, -1, -1, -1, 1'b0);   run("restart", 2, -1);
    build(1, 1, -1, 3, -1, 1'b0);    run("silent", 1, -1);
    build(0, 1, -1, 2, 0, 1'b0);     run("both_n0", 0, -1);
    for (int k = 0; k < 6; k++) begin
      n = (k == 0) ? 0 : int'($urandom_range(0, 9));
      build(n, 2, rnd() ? int'($urandom_range(0, RST_C - 1)) : -1, -1, -1, 1'b1);
      run($sformatf("rand%0d", k), n, -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
